core_sequencer: RTL and testbench
=================================

# core_sequencer

Program sequencer for the GPU core array. It holds a small program of 16-bit opcodes and steps through it, one opcode per cycle, onto the shared `opcode`/`execute` bus that every `core` instance samples. It also interprets two sequencer-only instructions, END and LOOP, which are never forwarded to the cores. It sits between the host/control logic that loads the program and starts a run, and the core array.

## Interface
Parameters:
- `PROG_DEPTH`, 16: program memory entries; fixed at 16, so PC is 4 bits.
- `LOOP_CNT_WIDTH`, 8: width of the loop counter.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `prog_we`  in  1  program memory write enable.
- `prog_addr`  in  4  program memory write address.
- `prog_data`  in  16  program memory write data.
- `start`  in  1  begin a run at address 0; honoured only in IDLE.
- `stop`  in  1  abort the run; honoured only in RUN.
- `opcode`  out  16  opcode to the cores; registered.
- `execute`  out  1  the `opcode` bus is valid this cycle; registered.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse when END retires.
- `pc`  out  4  current fetch address.

## Operation
- States:
  - IDLE: `start`=1 sets `pc`←0, clears loop state and moves to RUN.
  - RUN: each cycle fetches `mem[pc]` (combinational array read) and decodes it.
- Decode in RUN, where `i` = `mem[pc]`:
  - `i[15:14]`≠2'b10 (core opcode): `opcode`←`i`, `execute`←1, `pc`←`pc`+1.
  - `i[15:12]`=4'b1000 (END): `execute`←0, `done`←1, state←IDLE.
  - `i[15:12]`=4'b1001 (LOOP): target=`i[11:8]`, count=`i[7:0]`. `execute`←0.
    - Not armed: if count=0, `pc`+1; otherwise armed←1, `loop_cnt`←count−1, `pc`←target.
    - Armed: if `loop_cnt`=0, armed←0 and `pc`+1; otherwise `loop_cnt`−1 and `pc`←target.
    - Net effect: the body executes count+1 times in total. There is a single nesting level. A LOOP reached while armed (including a different LOOP) uses the armed counter.
  - `i[15:12]`=4'b1010 or 4'b1011 (reserved): NOP. `execute`←0, `pc`+1.
- `opcode` holds its last value whenever `execute`=0.
- PC arithmetic is modulo 16. Without an END, PC wraps 15→0 and the run continues until `stop`.
- Program writes:
  - Accepted only in IDLE; writes in RUN are dropped.
  - When `prog_we` and `start` arrive in the same IDLE cycle, the write completes first and the run sees the new data.
- `stop` in RUN: `execute`←0, state←IDLE, no `done`, loop state cleared.
- `start` in RUN is ignored.
- Priority: `rst` > `stop` > decode.
- Reset values: state IDLE, `pc`=0, `opcode`=0, `execute`=0, `done`=0, `busy`=0, loop state cleared. Program memory is not reset and keeps its contents across `rst`.

## Timing
- `start` sampled at edge E0: `busy`=1 after E0.
- First `execute`=1 with `opcode`=`mem[0]` after E1.
- Throughput is one instruction per cycle. END, LOOP and NOP each cost one cycle with `execute`=0.
- END fetched in the cycle after edge Ek: after edge Ek+1, `done`=1 and `busy`=0. `done` drops after the following edge.
- `stop` sampled at edge E: `execute`=0 and `busy`=0 after E.
- `rst` sampled at edge E: all outputs at their reset values after E.
- Cores sample `opcode`/`execute` on the same `clk`, so the sequencer adds no extra latency.

## Configuration
- `CORE_SEQ_LOOP_EN` defined: the LOOP instruction is implemented as described, with `loop_cnt` and the armed flag.
- Not defined: the LOOP encoding is decoded as a NOP (`execute`=0, `pc`+1), and no loop registers are instantiated.

## Test plan
- Straight-line run: mem0=16'h0105, mem1=16'h0207, mem2=16'h4000, mem3=16'h8000; pulse `start` → `execute`=1 for exactly 3 consecutive cycles with opcodes 0105, 0207, 4000. Then `done` pulses one cycle later, `busy` drops and `pc` equals 3 at END.
- Loop (macro defined): mem0=A, mem1=B, mem2=16'h9102 (target 1, count 2), mem3=END → executed opcodes are A, B, gap, B, gap, B, gap; then `done`. Total `execute` cycles = 4. With the macro undefined, the executed opcodes are A, B only.
- Abort: `stop` while `pc`=2 → `execute`=0 next cycle, no `done`. A subsequent `start` replays from `mem[0]`.
- Ignored requests: `start` in RUN causes no PC reset. A `prog_we` in RUN that targets a later address is dropped, so a rerun shows the old opcode.
- Reset mid-run: `rst` in RUN → `opcode`=0, `execute`=0, `busy`=0 next cycle. A rerun yields an identical opcode sequence, confirming memory was retained.
- Wrap: program with no END → `pc` sequence 14, 15, 0, 1 with `execute` continuous; then `stop` ends the run.

Source files
------------

// File: rtl/core_sequencer.sv
// core_sequencer: steps a 16-entry opcode program onto the core opcode/execute bus.
// Optional LOOP support is enabled by defining CORE_SEQ_LOOP_EN.
module core_sequencer #(
  parameter int PROG_DEPTH     = 16,
  parameter int LOOP_CNT_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        prog_we,
  input  logic [3:0]  prog_addr,
  input  logic [15:0] prog_data,
  input  logic        start,
  input  logic        stop,
  output logic [15:0] opcode,
  output logic        execute,
  output logic        busy,
  output logic        done,
  output logic [3:0]  pc
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t      state_q;
  logic [3:0]  pc_q, pc_d;
  logic [15:0] opcode_q;
  logic        execute_q, done_q;
  logic [15:0] mem [PROG_DEPTH];
  logic [15:0] instr;
  logic        is_core, is_end, is_loop;
  assign instr   = mem[pc_q];
  assign is_core = instr[15:14] != 2'b10;
  assign is_end  = instr[15:12] == 4'b1000;
  assign is_loop = instr[15:12] == 4'b1001;
`ifdef CORE_SEQ_LOOP_EN
  logic                      armed_q;
  logic [LOOP_CNT_WIDTH-1:0] loop_cnt_q, loop_cnt_d, count;
  logic                      armed_d, loop_take;
  assign count = LOOP_CNT_WIDTH'(instr[7:0]);
  always_comb begin
    loop_take  = is_loop && (armed_q ? loop_cnt_q != '0 : count != '0);
    armed_d    = is_loop ? loop_take : armed_q;
    loop_cnt_d = !is_loop ? loop_cnt_q : !loop_take ? '0 : armed_q ? loop_cnt_q - 1'b1 : count - 1'b1;
    pc_d       = is_end ? pc_q : loop_take ? instr[11:8] : pc_q + 4'd1;
  end
`else
  always_comb pc_d = is_end ? pc_q : pc_q + 4'd1;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      opcode_q   <= '0;
      execute_q  <= 1'b0;
      done_q     <= 1'b0;
`ifdef CORE_SEQ_LOOP_EN
      armed_q    <= 1'b0;
      loop_cnt_q <= '0;
`endif
    end else begin
      execute_q <= 1'b0;
      done_q    <= 1'b0;
      if (state_q == IDLE) begin
        if (start) begin
          state_q    <= RUN;
          pc_q       <= '0;
`ifdef CORE_SEQ_LOOP_EN
          armed_q    <= 1'b0;
          loop_cnt_q <= '0;
`endif
        end
      end else if (stop) begin
        state_q    <= IDLE;
`ifdef CORE_SEQ_LOOP_EN
        armed_q    <= 1'b0;
        loop_cnt_q <= '0;
`endif
      end else begin
        pc_q <= pc_d;
        if (is_core) begin
          opcode_q  <= instr;
          execute_q <= 1'b1;
        end
        if (is_end) begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
`ifdef CORE_SEQ_LOOP_EN
        armed_q    <= armed_d;
        loop_cnt_q <= loop_cnt_d;
`endif
      end
    end
  end
  // Program memory is deliberately not reset so a program survives rst.
  always_ff @(posedge clk) begin
    if (prog_we && state_q == IDLE) mem[prog_addr] <= prog_data;
  end
  assign opcode  = opcode_q;
  assign execute = execute_q;
  assign busy    = state_q == RUN;
  assign done    = done_q;
  assign pc      = pc_q;
endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: directed self-checking bench for core_sequencer.
module tb_core_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [15:0] prog_data = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] opcode;
  logic        execute, busy, done;
  logic [3:0]  pc;
  int          tests = 0;
  int          fails = 0;
  logic [15:0] got[$];
  logic        got_done;
`ifdef CORE_SEQ_LOOP_EN
  localparam int LOOP_N = 4;
`else
  localparam int LOOP_N = 2;
`endif

  core_sequencer dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .start(start), .stop(stop), .opcode(opcode), .execute(execute), .busy(busy),
    .done(done), .pc(pc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [15:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    step();
    prog_we = 1'b0;
  endtask

  task automatic load_straight();
    load(4'd0, 16'h0105); load(4'd1, 16'h0207); load(4'd2, 16'h4000); load(4'd3, 16'h8000);
  endtask

  // Starts a run and records every executed opcode until done or the budget expires.
  task automatic run_collect(input int budget);
    got.delete();
    got_done = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < budget && !got_done; c++) begin
      step();
      if (execute) got.push_back(opcode);
      if (done) got_done = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    tests++; if (opcode !== 16'h0) begin fails++; $display("FAIL reset_opcode got %h exp 0000", opcode); end
    tests++; if (execute !== 1'b0) begin fails++; $display("FAIL reset_execute got %b exp 0", execute); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", done); end
    tests++; if (pc !== 4'd0) begin fails++; $display("FAIL reset_pc got %0d exp 0", pc); end
  endtask

  task automatic test_straight();
    load_straight();
    start = 1'b1;
    step();
    start = 1'b0;
    tests++; if (busy !== 1'b1 || execute !== 1'b0) begin fails++; $display("FAIL straight_e0 busy %b exec %b exp 1 0", busy, execute); end
    step();
    tests++; if (execute !== 1'b1 || opcode !== 16'h0105) begin fails++; $display("FAIL straight_op0 exec %b op %h exp 1 0105", execute, opcode); end
    step();
    tests++; if (execute !== 1'b1 || opcode !== 16'h0207) begin fails++; $display("FAIL straight_op1 exec %b op %h exp 1 0207", execute, opcode); end
    step();
    tests++; if (execute !== 1'b1 || opcode !== 16'h4000 || pc !== 4'd3) begin fails++; $display("FAIL straight_op2 exec %b op %h pc %0d exp 1 4000 3", execute, opcode, pc); end
    step();
    tests++; if (done !== 1'b1 || busy !== 1'b0 || execute !== 1'b0) begin fails++; $display("FAIL straight_end done %b busy %b exec %b exp 1 0 0", done, busy, execute); end
    tests++; if (pc !== 4'd3 || opcode !== 16'h4000) begin fails++; $display("FAIL straight_hold pc %0d op %h exp 3 4000", pc, opcode); end
    step();
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL straight_done_pulse got %b exp 0", done); end
  endtask

  task automatic test_loop();
    logic [15:0] exp_q[$];
    exp_q = '{16'h1111, 16'h2222, 16'h2222, 16'h2222};
    load(4'd0, 16'h1111); load(4'd1, 16'h2222); load(4'd2, 16'h9102); load(4'd3, 16'h8000);
    run_collect(40);
    tests++; if (got_done !== 1'b1) begin fails++; $display("FAIL loop_done got %b exp 1", got_done); end
    tests++; if (got.size() != LOOP_N) begin fails++; $display("FAIL loop_count got %0d exp %0d", got.size(), LOOP_N); end
    for (int k = 0; k < LOOP_N && k < got.size(); k++) begin
      tests++; if (got[k] !== exp_q[k]) begin fails++; $display("FAIL loop_op%0d got %h exp %h", k, got[k], exp_q[k]); end
    end
  endtask

  task automatic test_abort();
    logic seen_done;
    load_straight();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    tests++; if (pc !== 4'd2) begin fails++; $display("FAIL abort_pc got %0d exp 2", pc); end
    stop = 1'b1;
    step();
    stop = 1'b0;
    tests++; if (execute !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL abort_stop exec %b busy %b exp 0 0", execute, busy); end
    seen_done = done;
    for (int c = 0; c < 4; c++) begin step(); seen_done |= done; end
    tests++; if (seen_done !== 1'b0) begin fails++; $display("FAIL abort_no_done got %b exp 0", seen_done); end
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    tests++; if (execute !== 1'b1 || opcode !== 16'h0105) begin fails++; $display("FAIL abort_replay exec %b op %h exp 1 0105", execute, opcode); end
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_ignored();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    start = 1'b1; prog_we = 1'b1; prog_addr = 4'd2; prog_data = 16'h1234;
    step();
    start = 1'b0; prog_we = 1'b0;
    tests++; if (pc !== 4'd2 || opcode !== 16'h0207) begin fails++; $display("FAIL ignored_start pc %0d op %h exp 2 0207", pc, opcode); end
    step();
    tests++; if (opcode !== 16'h4000) begin fails++; $display("FAIL ignored_write got %h exp 4000", opcode); end
    step();
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL ignored_done got %b exp 1", done); end
    run_collect(20);
    tests++; if (got.size() != 3 || got[2] !== 16'h4000) begin fails++; $display("FAIL ignored_rerun size %0d exp 3 / third op exp 4000", got.size()); end
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++; if (opcode !== 16'h0 || execute !== 1'b0 || busy !== 1'b0 || pc !== 4'd0) begin fails++; $display("FAIL midrst op %h exec %b busy %b pc %0d exp 0000 0 0 0", opcode, execute, busy, pc); end
    run_collect(20);
    tests++; if (got_done !== 1'b1 || got.size() != 3) begin fails++; $display("FAIL midrst_rerun done %b size %0d exp 1 3", got_done, got.size()); end
    if (got.size() == 3) begin
      tests++; if (got[0] !== 16'h0105 || got[1] !== 16'h0207 || got[2] !== 16'h4000) begin fails++; $display("FAIL midrst_seq got %h %h %h exp 0105 0207 4000", got[0], got[1], got[2]); end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_pc;
    for (int k = 0; k < 16; k++) load(4'(k), 16'h0100 + 16'(k));
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 14; k++) step();
    for (int k = 14; k < 18; k++) begin
      exp_pc = 4'(k);
      tests++; if (pc !== exp_pc || execute !== 1'b1) begin fails++; $display("FAIL wrap_pc%0d pc %0d exec %b exp %0d 1", k, pc, execute, exp_pc); end
      step();
    end
    tests++; if (opcode !== 16'h0101) begin fails++; $display("FAIL wrap_op got %h exp 0101", opcode); end
    stop = 1'b1;
    step();
    stop = 1'b0;
    tests++; if (busy !== 1'b0 || execute !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL wrap_stop busy %b exec %b done %b exp 0 0 0", busy, execute, done); end
  endtask

  initial begin
    test_reset();
    test_straight();
    test_loop();
    test_abort();
    test_ignored();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
